item_laser_beam: RTL and testbench

//  Parametrised, timed successor of the laser reward overlay. On a fire

---
 rtl/item_laser_beam_if.sv | 30 +++
 rtl/item_laser_beam.sv | 144 ++++++++++++++
 tb/tb_item_laser_beam.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/item_laser_beam_if.sv
// item_laser_beam_if: reward controls, tank pose, scan position and overlay/status lines of the laser beam
// Fields:
//   enable_reward, item_laser, fire, frame_tick    controller -> beam
//   mytank_xpos, mytank_ypos, mytank_dir           tank grid position and facing
//   VGA_xpos, VGA_ypos                             current scan position
//   VGA_data, laser_active, laser_ready            beam -> mixer / game controller
interface item_laser_beam_if;
    logic        enable_reward;
    logic        item_laser;
    logic        fire;
    logic        frame_tick;
    logic [4:0]  mytank_xpos;
    logic [4:0]  mytank_ypos;
    logic [1:0]  mytank_dir;
    logic [10:0] VGA_xpos;
    logic [10:0] VGA_ypos;
    logic [11:0] VGA_data;
    logic        laser_active;
    logic        laser_ready;
    modport master (
        output enable_reward, item_laser, fire, frame_tick,
        output mytank_xpos, mytank_ypos, mytank_dir, VGA_xpos, VGA_ypos,
        input  VGA_data, laser_active, laser_ready
    );
    modport slave (
        input  enable_reward, item_laser, fire, frame_tick,
        input  mytank_xpos, mytank_ypos, mytank_dir, VGA_xpos, VGA_ypos,
        output VGA_data, laser_active, laser_ready
    );
endinterface

// File: rtl/item_laser_beam.sv
// item_laser_beam: timed laser overlay that grows from the tank muzzle per frame, holds, then cools down
// Ports:
//   clk          system/pixel clock
//   rst_n        asynchronous active-low reset
//   bus (slave)  enable_reward/item_laser/fire/frame_tick, tank pose, VGA scan
//                position in; registered VGA_data overlay pixel (0 = transparent),
//                laser_active (EXTEND/HOLD) and laser_ready (armed in IDLE) out
module item_laser_beam #(
    parameter int          CELL        = 20,
    parameter int          ORIGIN_X    = 80,
    parameter int          ORIGIN_Y    = 80,
    parameter int          HALF_W      = 2,
    parameter int          GAP         = 10,
    parameter int          FIELD_X0    = 70,
    parameter int          FIELD_X1    = 570,
    parameter int          FIELD_Y0    = 70,
    parameter int          FIELD_Y1    = 330,
    parameter int          STEP        = 40,
    parameter int          HOLD_FRAMES = 30,
    parameter int          COOL_FRAMES = 60,
    parameter logic [11:0] COLOR       = 12'hFF0
) (
    input logic              clk,
    input logic              rst_n,
    item_laser_beam_if.slave bus
);
    localparam int CW = $clog2((HOLD_FRAMES > COOL_FRAMES ? HOLD_FRAMES : COOL_FRAMES) + 1);
    typedef enum logic [1:0] {IDLE, EXTEND, HOLD, COOL} state_t;
    state_t        state, state_n;
    logic [11:0]   cx, cy, len, max_len, cx_n, cy_n, len_n, max_len_n;
    logic [1:0]    dir, dir_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          armed, on_x, on_y, hit;
    logic [11:0]   vga_q;
    logic          active_q, ready_q;
    int            tx, ty, reach, grown, px, py, bx, by, bl;
    assign armed = bus.enable_reward && bus.item_laser;
    always_comb begin
        state_n   = state;
        cx_n      = cx;
        cy_n      = cy;
        dir_n     = dir;
        len_n     = len;
        max_len_n = max_len;
        cnt_n     = cnt;
        // Muzzle-to-bound distance for the live tank pose; only latched on fire.
        tx    = int'(bus.mytank_xpos) * CELL + ORIGIN_X;
        ty    = int'(bus.mytank_ypos) * CELL + ORIGIN_Y;
        reach = bus.mytank_dir == 2'b00 ? ty - GAP - FIELD_Y0 :
                bus.mytank_dir == 2'b01 ? FIELD_Y1 - (ty + GAP) :
                bus.mytank_dir == 2'b10 ? tx - GAP - FIELD_X0 :
                                          FIELD_X1 - (tx + GAP);
        reach = reach < 0 ? 0 : reach;
        grown = int'(len) + STEP;
        if (!bus.enable_reward) begin
            state_n = IDLE;
            len_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: if (bus.fire && bus.item_laser) begin
                    cx_n      = 12'(tx);
                    cy_n      = 12'(ty);
                    dir_n     = bus.mytank_dir;
                    max_len_n = 12'(reach);
                    len_n     = '0;
                    cnt_n     = '0;
                    state_n   = EXTEND;
                end
                // Saturating growth: a zero-length shot reaches HOLD on its first tick.
                EXTEND: if (bus.frame_tick) begin
                    if (grown >= int'(max_len)) begin
                        len_n   = max_len;
                        cnt_n   = '0;
                        state_n = HOLD;
                    end else begin
                        len_n = 12'(grown);
                    end
                end
                HOLD: if (bus.frame_tick) begin
                    if (cnt == CW'(HOLD_FRAMES - 1)) begin
                        cnt_n   = '0;
                        state_n = COOL;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                COOL: if (bus.frame_tick) begin
                    if (cnt == CW'(COOL_FRAMES - 1)) begin
                        cnt_n   = '0;
                        len_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_comb begin
        px   = int'(bus.VGA_xpos);
        py   = int'(bus.VGA_ypos);
        bx   = int'(cx);
        by   = int'(cy);
        bl   = int'(len);
        on_x = px >= bx - HALF_W && px <= bx + HALF_W;
        on_y = py >= by - HALF_W && py <= by + HALF_W;
        hit  = (state == EXTEND || state == HOLD) && len != '0 &&
               (dir == 2'b00 ? on_x && py >= by - GAP - bl && py <= by - GAP :
                dir == 2'b01 ? on_x && py >= by + GAP && py <= by + GAP + bl :
                dir == 2'b10 ? on_y && px >= bx - GAP - bl && px <= bx - GAP :
                               on_y && px >= bx + GAP && px <= bx + GAP + bl);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cx       <= '0;
            cy       <= '0;
            dir      <= '0;
            len      <= '0;
            max_len  <= '0;
            cnt      <= '0;
            vga_q    <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_n;
            cx       <= cx_n;
            cy       <= cy_n;
            dir      <= dir_n;
            len      <= len_n;
            max_len  <= max_len_n;
            cnt      <= cnt_n;
            vga_q    <= bus.enable_reward && hit ? COLOR : 12'h000;
            // Flags follow the state being entered so they line up with it.
            active_q <= state_n == EXTEND || state_n == HOLD;
            ready_q  <= state_n == IDLE && armed;
        end
    end
    assign bus.VGA_data     = vga_q;
    assign bus.laser_active = active_q;
    assign bus.laser_ready  = ready_q;
endmodule

// File: tb/tb_item_laser_beam.sv
// tb_item_laser_beam: directed and randomized checks of item_laser_beam against a rectangle-based beam model
module tb_item_laser_beam;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_on = 1'b0;
    int   errors = 0;
    int   checks = 0;
    item_laser_beam_if bus();
    item_laser_beam dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // ph: 0 idle, 1 growing, 2 holding, 3 cooling; n counts frames in the current phase
    typedef struct packed {
        int ph;
        int cx;
        int cy;
        int dir;
        int len;
        int maxl;
        int n;
    } model_t;
    model_t      m;
    logic [11:0] exp_vga;
    logic        exp_act, exp_rdy;

    function automatic int reach(int cx, int cy, int dir);
        int d;
        d = dir == 0 ? (cy - 10) - 70 : dir == 1 ? 330 - (cy + 10) : dir == 2 ? (cx - 10) - 70 : 570 - (cx + 10);
        return d < 0 ? 0 : d;
    endfunction

    function automatic model_t advance(model_t s);
        model_t r;
        r = s;
        if (!bus.enable_reward) begin
            r.ph = 0; r.len = 0; r.n = 0;
        end else if (s.ph == 0) begin
            if (bus.fire && bus.item_laser) begin
                r.cx = int'(bus.mytank_xpos) * 20 + 80;
                r.cy = int'(bus.mytank_ypos) * 20 + 80;
                r.dir = int'(bus.mytank_dir);
                r.maxl = reach(r.cx, r.cy, r.dir);
                r.len = 0; r.n = 0; r.ph = 1;
            end
        end else if (bus.frame_tick) begin
            if (s.ph == 1) begin
                r.len = s.len + 40 < s.maxl ? s.len + 40 : s.maxl;
                if (r.len == s.maxl) begin r.ph = 2; r.n = 0; end
            end else begin
                r.n = s.n + 1;
                if (s.ph == 2 && r.n == 30) begin r.ph = 3; r.n = 0; end
                else if (s.ph == 3 && r.n == 60) begin r.ph = 0; r.n = 0; r.len = 0; end
            end
        end
        return r;
    endfunction

    function automatic bit lit(model_t s, int x, int y);
        int x0, x1, y0, y1;
        if (!(s.ph == 1 || s.ph == 2) || s.len == 0) return 1'b0;
        if (s.dir < 2) begin
            x0 = s.cx - 2; x1 = s.cx + 2;
            y0 = s.dir == 0 ? s.cy - 10 - s.len : s.cy + 10; y1 = y0 + s.len;
        end else begin
            y0 = s.cy - 2; y1 = s.cy + 2;
            x0 = s.dir == 2 ? s.cx - 10 - s.len : s.cx + 10; x1 = x0 + s.len;
        end
        return x >= x0 && x <= x1 && y >= y0 && y <= y1;
    endfunction

    function automatic bit act_after(model_t s);
        model_t r;
        r = advance(s);
        return r.ph == 1 || r.ph == 2;
    endfunction

    function automatic bit rdy_after(model_t s);
        model_t r;
        r = advance(s);
        return r.ph == 0 && bus.enable_reward && bus.item_laser;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '0;
            exp_vga <= 12'h000;
            exp_act <= 1'b0;
            exp_rdy <= 1'b0;
        end else begin
            m <= advance(m);
            exp_vga <= bus.enable_reward && lit(m, int'(bus.VGA_xpos), int'(bus.VGA_ypos)) ? 12'hFF0 : 12'h000;
            exp_act <= act_after(m);
            exp_rdy <= rdy_after(m);
        end
    end

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_vga", int'(bus.VGA_data), int'(exp_vga));
            check("model_active", int'(bus.laser_active), int'(exp_act));
            check("model_ready", int'(bus.laser_ready), int'(exp_rdy));
        end
    end

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic shoot(int x, int y, int d);
        bus.mytank_xpos = 5'(x);
        bus.mytank_ypos = 5'(y);
        bus.mytank_dir = 2'(d);
        bus.fire = 1'b1;
        @(negedge clk);
        bus.fire = 1'b0;
    endtask

    task automatic probe(int x, int y, int want, string name);
        bus.VGA_xpos = 11'(x);
        bus.VGA_ypos = 11'(y);
        @(negedge clk);
        check(name, int'(bus.VGA_data), want);
    endtask

    initial begin
        bus.enable_reward = 1'b1;
        bus.item_laser = 1'b1;
        bus.fire = 1'b0;
        bus.frame_tick = 1'b0;
        bus.mytank_xpos = '0;
        bus.mytank_ypos = '0;
        bus.mytank_dir = '0;
        bus.VGA_xpos = '0;
        bus.VGA_ypos = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset_vga", int'(bus.VGA_data), 0);
        check("reset_active", int'(bus.laser_active), 0);
        check("reset_ready", int'(bus.laser_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(bus.laser_ready), 1);

        // grow up from tank (5,4): centre (180,160), reach 80
        shoot(5, 4, 0);
        check("t2_extend_active", int'(bus.laser_active), 1);
        check("t2_extend_ready", int'(bus.laser_ready), 0);
        tick();
        probe(180, 110, 'hFF0, "t2_tip");
        probe(178, 150, 'hFF0, "t2_root_left");
        probe(182, 130, 'hFF0, "t2_right_edge");
        probe(180, 109, 0, "t2_above_tip");
        probe(177, 130, 0, "t2_left_out");
        probe(183, 130, 0, "t2_right_out");
        probe(180, 151, 0, "t2_gap");
        bus.mytank_xpos = 5'd10;
        tick();
        probe(180, 70, 'hFF0, "t2_full_tip");
        probe(180, 69, 0, "t2_past_field");
        check("t2_hold_active", int'(bus.laser_active), 1);

        repeat (29) tick();
        check("t3_hold_29", int'(bus.laser_active), 1);
        tick();
        check("t3_cool_active", int'(bus.laser_active), 0);
        check("t3_cool_ready", int'(bus.laser_ready), 0);
        probe(180, 100, 0, "t3_cool_dark");
        repeat (59) tick();
        check("t3_cool_59", int'(bus.laser_ready), 0);
        tick();
        check("t3_rearmed", int'(bus.laser_ready), 1);

        // asynchronous reset in the middle of HOLD
        shoot(5, 4, 0);
        tick();
        tick();
        probe(180, 100, 'hFF0, "t1_pre_reset");
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_vga", int'(bus.VGA_data), 0);
        check("t1_async_active", int'(bus.laser_active), 0);
        check("t1_async_ready", int'(bus.laser_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_ready_again", int'(bus.laser_ready), 1);

        // tank (0,0) facing left: zero reach
        shoot(0, 0, 2);
        tick();
        check("t4_hold_active", int'(bus.laser_active), 1);
        probe(70, 80, 0, "t4_muzzle");
        probe(69, 80, 0, "t4_bound");
        repeat (30) tick();
        check("t4_cooling", int'(bus.laser_active), 0);
        repeat (60) tick();

        // fire ignored without the item, in EXTEND and in COOL
        bus.item_laser = 1'b0;
        @(negedge clk);
        check("t5_no_item_ready", int'(bus.laser_ready), 0);
        shoot(5, 4, 0);
        @(negedge clk);
        check("t5_no_item_idle", int'(bus.laser_active), 0);
        bus.item_laser = 1'b1;
        @(negedge clk);
        shoot(5, 4, 0);
        tick();
        shoot(1, 1, 3);
        probe(180, 110, 'hFF0, "t5_extend_fire");
        tick();
        repeat (30) tick();
        shoot(5, 4, 0);
        check("t5_cool_fire", int'(bus.laser_active), 0);
        repeat (60) tick();

        // enable_reward dropped while growing
        shoot(5, 4, 0);
        tick();
        probe(180, 120, 'hFF0, "t6_before_drop");
        bus.enable_reward = 1'b0;
        @(negedge clk);
        check("t6_vga", int'(bus.VGA_data), 0);
        check("t6_active", int'(bus.laser_active), 0);
        check("t6_ready", int'(bus.laser_ready), 0);
        bus.enable_reward = 1'b1;
        @(negedge clk);
        check("t6_idle_ready", int'(bus.laser_ready), 1);
        tick();
        probe(180, 120, 0, "t6_no_beam");

        for (int i = 0; i < 20000; i++) begin
            bus.enable_reward = $urandom_range(0, 63) != 0;
            bus.item_laser = $urandom_range(0, 15) != 0;
            bus.fire = $urandom_range(0, 7) == 0;
            bus.frame_tick = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 31) == 0) begin
                bus.mytank_xpos = 5'($urandom_range(0, 31));
                bus.mytank_ypos = 5'($urandom_range(0, 31));
                bus.mytank_dir = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.VGA_xpos = 11'($urandom_range(0, 2047));
                bus.VGA_ypos = 11'($urandom_range(0, 2047));
            end else if (m.dir < 2) begin
                bus.VGA_xpos = 11'(m.cx + int'($urandom_range(0, 8)) - 4);
                bus.VGA_ypos = 11'($urandom_range(40, 720));
            end else begin
                bus.VGA_xpos = 11'($urandom_range(40, 720));
                bus.VGA_ypos = 11'(m.cy + int'($urandom_range(0, 8)) - 4);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
